// File: rtl/alu_op_driver.sv
// alu_op_driver: command-side initiator for the 8-bit combinational ALU.
// Registers operands/select toward the ALU, captures result and flags one
// cycle later, and returns them over a valid/ready response channel.
// Keeps an accumulator for chained operations and a completed-op counter.
// Optional build macro ALU_OP_DRIVER_CHECK_EN adds a golden-model checker
// with a sticky mismatch flag (chk_err) and the select of the first miss.
module alu_op_driver #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [2:0]        cmd_sel,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_count
`ifdef ALU_OP_DRIVER_CHECK_EN
    ,
    output logic              chk_err,
    output logic [2:0]        chk_err_sel
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic cmd_fire;
    logic exec_cap;
    logic rsp_fire;

    // State register; reset returns to IDLE and drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode; cmd_ready depends on state only.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        cmd_fire   = 1'b0;
        exec_cap   = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire   = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                exec_cap   = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_fire   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operand registers; they only change on an accepted command so the
    // combinational ALU inputs stay quiet outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (cmd_fire) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
        end
    end

    // Result capture at the end of EXEC; accumulator follows the ALU output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            acc       <= '0;
        end else if (exec_cap) begin
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_zero  <= alu_zero;
            acc       <= alu_out;
        end
    end

    // Response valid and completed-op counter (wraps silently).
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            if (exec_cap) begin
                rsp_valid <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_OP_DRIVER_CHECK_EN
    logic [DATA_W:0]   gold_wide;
    logic [DATA_W-1:0] gold_data;
    logic              gold_carry;
    logic              gold_zero;
    logic              chk_miss;

    // Reference ALU evaluated on the registered operands; the extra top bit
    // carries add carry-out / subtract borrow and is zero for all other ops.
    always_comb begin
        gold_wide = '0;
        case (alu_sel)
            3'b000:  gold_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  gold_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  gold_wide = {1'b0, alu_a & alu_b};
            3'b011:  gold_wide = {1'b0, alu_a | alu_b};
            3'b100:  gold_wide = {1'b0, alu_a ^ alu_b};
            3'b101:  gold_wide = {1'b0, ~alu_a};
            3'b110:  gold_wide = {1'b0, alu_a << 1};
            default: gold_wide = {1'b0, alu_a >> 1};
        endcase
        gold_data  = gold_wide[DATA_W-1:0];
        gold_carry = gold_wide[DATA_W];
        gold_zero  = (gold_data == '0);
        chk_miss   = exec_cap && ((gold_data != alu_out) ||
                                  (gold_carry != alu_carry) ||
                                  (gold_zero != alu_zero));
    end

    // Sticky error flag; only the first mismatching select is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err     <= 1'b0;
            chk_err_sel <= '0;
        end else if (chk_miss && !chk_err) begin
            chk_err     <= 1'b1;
            chk_err_sel <= alu_sel;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed testbench for alu_op_driver with a behavioural 8-bit ALU attached.
// Counter width is reduced so the wrap boundary is reachable quickly.
// Build with ALU_OP_DRIVER_CHECK_EN to also exercise the checker ports.
module tb_alu_op_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [7:0] acc;
    logic [3:0] op_count;
`ifdef ALU_OP_DRIVER_CHECK_EN
    logic       chk_err;
    logic [2:0] chk_err_sel;
`endif

    // ALU fault override used to provoke the checker.
    logic       force_en;
    logic [7:0] force_val;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_cnt;

    always #5 clk = ~clk;

    alu_op_driver #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .acc(acc), .op_count(op_count)
`ifdef ALU_OP_DRIVER_CHECK_EN
        , .chk_err(chk_err), .chk_err_sel(chk_err_sel)
`endif
    );

    // The combinational ALU the driver talks to.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_sel)
            3'b000:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_wide = {1'b0, alu_a & alu_b};
            3'b011:  alu_wide = {1'b0, alu_a | alu_b};
            3'b100:  alu_wide = {1'b0, alu_a ^ alu_b};
            3'b101:  alu_wide = {1'b0, ~alu_a};
            3'b110:  alu_wide = {1'b0, alu_a[6:0], 1'b0};
            default: alu_wide = {2'b00, alu_a[7:1]};
        endcase
        alu_out   = force_en ? force_val : alu_wide[7:0];
        alu_carry = alu_wide[8];
        alu_zero  = (alu_wide[7:0] == 8'h00);
    end

    // Operation table: sel, a, b, expected data, carry, zero (hand computed).
    logic [2:0] ov_sel [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000};
    logic [7:0] ov_a   [6] = '{8'hA5, 8'hA0, 8'hFF, 8'h0F, 8'h81, 8'h80};
    logic [7:0] ov_b   [6] = '{8'h0F, 8'h0A, 8'hFF, 8'h00, 8'h00, 8'h7F};
    logic [7:0] ov_d   [6] = '{8'h05, 8'hAA, 8'h00, 8'hF0, 8'h40, 8'hFF};
    logic       ov_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ov_z   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Present one command for one edge (driver assumed idle), then drop valid.
    task automatic send(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic ua);
        cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_use_acc = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 4'd0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_sel} !== 19'h0) begin n_err++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_a, alu_b, alu_sel}); end
        n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== 10'h0) begin n_err++; $display("FAIL reset_rsp_regs got=%h exp=0", {rsp_data, rsp_carry, rsp_zero}); end
        n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL reset_acc got=%h exp=00", acc); end
        n_cmp++; if (op_count !== 4'h0) begin n_err++; $display("FAIL reset_op_count got=%h exp=0", op_count); end
    endtask

    task automatic test_add_carry();
        send(3'b000, 8'hFF, 8'h01, 1'b0);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_exec_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL add_exec_ready got=%b exp=0", cmd_ready); end
        n_cmp++; if ({alu_a, alu_b, alu_sel} !== {8'hFF, 8'h01, 3'b000}) begin n_err++; $display("FAIL add_alu_in got=%h exp=%h", {alu_a, alu_b, alu_sel}, {8'hFF, 8'h01, 3'b000}); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_latency got=%b exp=1", rsp_valid); end
        n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== {8'h00, 1'b1, 1'b1}) begin n_err++; $display("FAIL add_rsp got=%h exp=%h", {rsp_data, rsp_carry, rsp_zero}, {8'h00, 1'b1, 1'b1}); end
        n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL add_acc got=%h exp=00", acc); end
        n_cmp++; if (op_count !== 4'd0) begin n_err++; $display("FAIL add_cnt_before got=%h exp=0", op_count); end
        handshake();
        n_cmp++; if (op_count !== 4'd1) begin n_err++; $display("FAIL add_cnt got=%h exp=1", op_count); end
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL add_return_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_sub_borrow();
        bit ok;
        send(3'b001, 8'h05, 8'h07, 1'b0);
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sub1_timeout got=no_rsp exp=rsp"); end
        n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== {8'hFE, 1'b1, 1'b0}) begin n_err++; $display("FAIL sub1_rsp got=%h exp=%h", {rsp_data, rsp_carry, rsp_zero}, {8'hFE, 1'b1, 1'b0}); end
        handshake();
        send(3'b001, 8'h07, 8'h05, 1'b0);
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sub2_timeout got=no_rsp exp=rsp"); end
        n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== {8'h02, 1'b0, 1'b0}) begin n_err++; $display("FAIL sub2_rsp got=%h exp=%h", {rsp_data, rsp_carry, rsp_zero}, {8'h02, 1'b0, 1'b0}); end
        handshake();
        n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL sub_cnt got=%h exp=%h", op_count, exp_cnt); end
    endtask

    task automatic test_acc_chain();
        bit ok;
        send(3'b000, 8'h10, 8'h20, 1'b0);
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_data !== 8'h30) begin n_err++; $display("FAIL chain1_rsp got=%h exp=30", rsp_data); end
        handshake();
        send(3'b110, 8'hAA, 8'h00, 1'b1);
        n_cmp++; if (alu_a !== 8'h30) begin n_err++; $display("FAIL chain_alu_a got=%h exp=30", alu_a); end
        wait_rsp(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL chain2_timeout got=no_rsp exp=rsp"); end
        n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== {8'h60, 1'b0, 1'b0}) begin n_err++; $display("FAIL chain2_rsp got=%h exp=%h", {rsp_data, rsp_carry, rsp_zero}, {8'h60, 1'b0, 1'b0}); end
        n_cmp++; if (acc !== 8'h60) begin n_err++; $display("FAIL chain_acc got=%h exp=60", acc); end
        handshake();
    endtask

    task automatic test_ops();
        bit ok;
        for (int i = 0; i < 6; i++) begin
            send(ov_sel[i], ov_a[i], ov_b[i], 1'b0);
            wait_rsp(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL op%0d_timeout got=no_rsp exp=rsp", i); end
            n_cmp++; if ({rsp_data, rsp_carry, rsp_zero} !== {ov_d[i], ov_c[i], ov_z[i]}) begin n_err++; $display("FAIL op%0d_rsp got=%h exp=%h", i, {rsp_data, rsp_carry, rsp_zero}, {ov_d[i], ov_c[i], ov_z[i]}); end
            handshake();
        end
        n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL ops_cnt got=%h exp=%h", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        send(3'b010, 8'hF0, 8'h3C, 1'b0);
        cmd_valid = 1'b1; cmd_sel = 3'b000; cmd_a = 8'h11; cmd_b = 8'h22;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL bp%0d_hs got=%b exp=10", i, {rsp_valid, cmd_ready}); end
            n_cmp++; if (rsp_data !== 8'h30) begin n_err++; $display("FAIL bp%0d_data got=%h exp=30", i, rsp_data); end
            n_cmp++; if ({alu_a, alu_b, alu_sel} !== {8'hF0, 8'h3C, 3'b010}) begin n_err++; $display("FAIL bp%0d_no_relatch got=%h exp=%h", i, {alu_a, alu_b, alu_sel}, {8'hF0, 8'h3C, 3'b010}); end
            n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL bp%0d_cnt got=%h exp=%h", i, op_count, exp_cnt); end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        handshake();
        n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL bp_cnt_release got=%h exp=%h", op_count, exp_cnt); end
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release_hs got=%b exp=01", {rsp_valid, cmd_ready}); end
        @(posedge clk); #1;
        n_cmp++; if ({alu_a, alu_sel} !== {8'hF0, 3'b010}) begin n_err++; $display("FAIL bp_hold_alu got=%h exp=%h", {alu_a, alu_sel}, {8'hF0, 3'b010}); end
    endtask

    task automatic test_idle_ready();
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b0;
        n_cmp++; if (op_count !== exp_cnt) begin n_err++; $display("FAIL idle_ready_cnt got=%h exp=%h", op_count, exp_cnt); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL idle_ready_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset_mid_op();
        send(3'b100, 8'h55, 8'hFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 4'd0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_exec_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL rst_exec_acc got=%h exp=00", acc); end
        n_cmp++; if (op_count !== 4'd0) begin n_err++; $display("FAIL rst_exec_cnt got=%h exp=0", op_count); end
        repeat (3) begin
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec_valid got=%b exp=0", rsp_valid); end
            @(posedge clk); #1;
        end
        // Reset colliding with a response handshake must win.
        send(3'b000, 8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; rst = 1'b0;
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rst_resp_hs got=%b exp=01", {rsp_valid, cmd_ready}); end
        n_cmp++; if ({op_count, acc} !== 12'h000) begin n_err++; $display("FAIL rst_resp_cnt_acc got=%h exp=000", {op_count, acc}); end
    endtask

    task automatic test_acc_after_reset();
        bit ok;
        send(3'b000, 8'hAA, 8'h05, 1'b1);
        n_cmp++; if (alu_a !== 8'h00) begin n_err++; $display("FAIL acc0_alu_a got=%h exp=00", alu_a); end
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_data !== 8'h05) begin n_err++; $display("FAIL acc0_rsp got=%h exp=05", rsp_data); end
        handshake();
    endtask

    task automatic test_wrap();
        bit ok;
        for (int i = 0; i < 20 && exp_cnt != 4'd15; i++) begin
            send(3'b011, 8'(i), 8'h00, 1'b0);
            wait_rsp(ok);
            handshake();
        end
        n_cmp++; if (op_count !== 4'd15) begin n_err++; $display("FAIL wrap_max got=%h exp=f", op_count); end
        send(3'b011, 8'h01, 8'h00, 1'b0);
        wait_rsp(ok);
        handshake();
        n_cmp++; if (op_count !== 4'd0) begin n_err++; $display("FAIL wrap_zero got=%h exp=0", op_count); end
    endtask

`ifdef ALU_OP_DRIVER_CHECK_EN
    task automatic test_check();
        bit ok;
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clean got=%b exp=0", chk_err); end
        force_en = 1'b1; force_val = 8'h01;
        send(3'b101, 8'h0F, 8'h00, 1'b0);
        wait_rsp(ok);
        force_en = 1'b0;
        n_cmp++; if (!ok || rsp_data !== 8'h01) begin n_err++; $display("FAIL chk_rsp_from_alu got=%h exp=01", rsp_data); end
        n_cmp++; if ({chk_err, chk_err_sel} !== 4'b1101) begin n_err++; $display("FAIL chk_flag got=%b exp=1101", {chk_err, chk_err_sel}); end
        handshake();
        send(3'b000, 8'h01, 8'h01, 1'b0);
        wait_rsp(ok);
        handshake();
        force_en = 1'b1; force_val = 8'h77;
        send(3'b010, 8'h0F, 8'h0F, 1'b0);
        wait_rsp(ok);
        force_en = 1'b0;
        handshake();
        n_cmp++; if ({chk_err, chk_err_sel} !== 4'b1101) begin n_err++; $display("FAIL chk_sticky got=%b exp=1101", {chk_err, chk_err_sel}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({chk_err, chk_err_sel} !== 4'b0000) begin n_err++; $display("FAIL chk_rst got=%b exp=0000", {chk_err, chk_err_sel}); end
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0; force_en = 1'b0; force_val = '0;
        exp_cnt = '0;
        @(posedge clk); #1;
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_acc_chain();
        test_ops();
        test_backpressure();
        test_idle_ready();
        test_reset_mid_op();
        test_acc_after_reset();
        test_wrap();
`ifdef ALU_OP_DRIVER_CHECK_EN
        test_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
